// File: rtl/rv_fetch_pkg.sv
// Shared fetch-stage types and constants: instruction idioms, FSM encoding, IF/ID record.
package rv_fetch_pkg;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [31:0] HALT_INSTR = 32'h0000_0063;
  localparam logic [31:0] PC_STEP    = 32'd4;

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } ifid_t;

  // Word-align a byte address; low two bits are never meaningful for fetch.
  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/ifetch_stage_if.sv
// Fetch-stage bus: control in, instruction memory port, IF/ID outputs.
interface ifetch_stage_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;
  logic        halted;

  modport master (
    input  stall, redirect_valid, redirect_pc, imem_instr,
    output imem_addr, if_valid, if_pc, if_pc_plus4, if_instr, halted
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, imem_instr,
    input  imem_addr, if_valid, if_pc, if_pc_plus4, if_instr, halted
  );
endinterface

// File: rtl/ifetch_stage_pc_reg.sv
// Program counter: async reset to RESET_PC, redirect beats hold beats advance.
module pc_reg
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        hold,
  output logic [31:0] pc
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           pc <= align_pc(RESET_PC);
    else if (redirect) pc <= align_pc(redirect_pc);
    else if (!hold)    pc <= pc + PC_STEP;
  end
endmodule

// File: rtl/ifetch_stage.sv
// Fetch stage: PC, IF/ID register and RUN/HALTED FSM on the halt idiom.
// Build option IFETCH_PERF_EN adds the fetch_count output.
module ifetch_stage
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  ifetch_stage_if.master     fif
`ifdef IFETCH_PERF_EN
  ,
  output logic [CNT_W-1:0]   fetch_count
`endif
);
  fetch_state_t state, state_nxt;
  ifid_t        ifid;
  logic [31:0]  pc;
  logic         halt_hit;
  logic         do_redirect, do_fetch, do_drain, pc_hold, halted_q;

  assign halt_hit = (fif.imem_instr == HALT_INSTR);

  pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk         (clk),
    .rst         (rst),
    .redirect    (do_redirect),
    .redirect_pc (fif.redirect_pc),
    .hold        (pc_hold),
    .pc          (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == RUN && !fif.redirect_valid && !fif.stall && halt_hit)
      state_nxt = HALTED;
  end

  // HALTED ignores redirect/stall except that stall keeps the halt word visible.
  always_comb begin
    do_redirect = 1'b0;
    do_fetch    = 1'b0;
    do_drain    = 1'b0;
    pc_hold     = 1'b1;
    halted_q    = 1'b0;
    case (state)
      RUN: begin
        if (fif.redirect_valid) begin
          do_redirect = 1'b1;
        end else if (!fif.stall) begin
          do_fetch = 1'b1;
          pc_hold  = halt_hit;
        end
      end
      HALTED: begin
        halted_q = 1'b1;
        do_drain = !fif.stall;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid.valid    <= 1'b0;
      ifid.pc       <= align_pc(RESET_PC);
      ifid.pc_plus4 <= align_pc(RESET_PC) + PC_STEP;
      ifid.instr    <= NOP_INSTR;
    end else if (do_redirect || do_drain) begin
      ifid.valid <= 1'b0;
      ifid.instr <= NOP_INSTR;
    end else if (do_fetch) begin
      ifid.valid    <= 1'b1;
      ifid.pc       <= pc;
      ifid.pc_plus4 <= pc + PC_STEP;
      ifid.instr    <= fif.imem_instr;
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           fetch_count <= '0;
    else if (do_fetch) fetch_count <= fetch_count + 1'b1;
  end
`endif

  assign fif.imem_addr   = pc;
  assign fif.if_valid    = ifid.valid;
  assign fif.if_pc       = ifid.pc;
  assign fif.if_pc_plus4 = ifid.pc_plus4;
  assign fif.if_instr    = ifid.instr;
  assign fif.halted      = halted_q;
endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage: fetch, stall, redirect, halt and reset cases.
module tb_ifetch_stage;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] HALT = 32'h0000_0063;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] mem [0:255];
  int n = 0;
  int fails = 0;

  ifetch_stage_if ifc ();

`ifdef IFETCH_PERF_EN
  logic [2:0] fetch_count;
`endif

  ifetch_stage #(.RESET_PC(32'h0), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .fif (ifc.master)
`ifdef IFETCH_PERF_EN
    ,
    .fetch_count (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  assign ifc.imem_instr = (ifc.imem_addr[31:10] == 22'd0) ? mem[ifc.imem_addr[9:2]] : NOP;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = NOP;
    mem[0]  = 32'h0010_0093;
    mem[1]  = 32'h0020_0113;
    mem[2]  = 32'h0030_0193;
    mem[3]  = 32'h0040_0213;
    mem[4]  = HALT;
    mem[8]  = 32'h0080_0413;
    mem[16] = 32'h00A0_0513;
    ifc.stall = 1'b0;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc = 32'h0;

    // reset state
    tick(); tick();
    chk("rst_addr", ifc.imem_addr, 32'h0);
    chk("rst_valid", ifc.if_valid, 1'b0);
    chk("rst_pc", ifc.if_pc, 32'h0);
    chk("rst_pc4", ifc.if_pc_plus4, 32'h4);
    chk("rst_instr", ifc.if_instr, NOP);
    chk("rst_halted", ifc.halted, 1'b0);
    rst = 1'b0;

    // sequential fetch
    tick();
    chk("f1_valid", ifc.if_valid, 1'b1);
    chk("f1_pc", ifc.if_pc, 32'h0);
    chk("f1_instr", ifc.if_instr, 32'h0010_0093);
    chk("f1_addr", ifc.imem_addr, 32'h4);
    chk("f1_pc4", ifc.if_pc_plus4, 32'h4);
    tick();
    chk("f2_addr", ifc.imem_addr, 32'h8);
    chk("f2_pc", ifc.if_pc, 32'h4);

    // stall holds pc and IF/ID
    ifc.stall = 1'b1;
    tick(); tick(); tick();
    chk("st_addr", ifc.imem_addr, 32'h8);
    chk("st_pc", ifc.if_pc, 32'h4);
    chk("st_instr", ifc.if_instr, 32'h0020_0113);
    ifc.stall = 1'b0;
    tick();
    chk("rs_pc", ifc.if_pc, 32'h8);
    chk("rs_addr", ifc.imem_addr, 32'hC);
    chk("rs_instr", ifc.if_instr, 32'h0030_0193);

    // redirect beats stall, low bits dropped
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc = 32'h43;
    ifc.stall = 1'b1;
    tick();
    chk("rd_addr", ifc.imem_addr, 32'h40);
    chk("rd_valid", ifc.if_valid, 1'b0);
    chk("rd_instr", ifc.if_instr, NOP);
    chk("rd_pc", ifc.if_pc, 32'h8);
    chk("rd_pc4", ifc.if_pc_plus4, 32'hC);
    ifc.redirect_valid = 1'b0;
    ifc.stall = 1'b0;
    tick();
    chk("rd2_valid", ifc.if_valid, 1'b1);
    chk("rd2_pc", ifc.if_pc, 32'h40);
    chk("rd2_instr", ifc.if_instr, 32'h00A0_0513);
    chk("rd2_addr", ifc.imem_addr, 32'h44);

    // async reset mid-run
    rst = 1'b1;
    #1;
    chk("ar_addr", ifc.imem_addr, 32'h0);
    chk("ar_valid", ifc.if_valid, 1'b0);
    tick();
    rst = 1'b0;

    // halt detection
    tick(); tick(); tick(); tick();
    chk("h0_addr", ifc.imem_addr, 32'h10);
    chk("h0_halted", ifc.halted, 1'b0);
    tick();
    chk("h1_valid", ifc.if_valid, 1'b1);
    chk("h1_instr", ifc.if_instr, HALT);
    chk("h1_pc", ifc.if_pc, 32'h10);
    chk("h1_halted", ifc.halted, 1'b1);
    chk("h1_addr", ifc.imem_addr, 32'h10);
    ifc.stall = 1'b1;
    tick();
    chk("h2_valid", ifc.if_valid, 1'b1);
    chk("h2_instr", ifc.if_instr, HALT);
    ifc.stall = 1'b0;
    tick();
    chk("h3_valid", ifc.if_valid, 1'b0);
    chk("h3_instr", ifc.if_instr, NOP);
    chk("h3_addr", ifc.imem_addr, 32'h10);
    chk("h3_pc", ifc.if_pc, 32'h10);
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc = 32'h100;
    tick();
    chk("h4_addr", ifc.imem_addr, 32'h10);
    chk("h4_halted", ifc.halted, 1'b1);
    chk("h4_valid", ifc.if_valid, 1'b0);
    ifc.redirect_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("hr_addr", ifc.imem_addr, 32'h0);
    chk("hr_halted", ifc.halted, 1'b0);
    tick();
    rst = 1'b0;

    // redirect on the halt-fetch edge suppresses the halt
    tick(); tick(); tick(); tick();
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc = 32'h20;
    tick();
    chk("rh_addr", ifc.imem_addr, 32'h20);
    chk("rh_halted", ifc.halted, 1'b0);
    chk("rh_valid", ifc.if_valid, 1'b0);
    chk("rh_pc", ifc.if_pc, 32'hC);
    ifc.redirect_valid = 1'b0;
    tick();
    chk("rh2_valid", ifc.if_valid, 1'b1);
    chk("rh2_pc", ifc.if_pc, 32'h20);
    chk("rh2_instr", ifc.if_instr, 32'h0080_0413);
    chk("rh2_halted", ifc.halted, 1'b0);
    chk("rh2_addr", ifc.imem_addr, 32'h24);

    // reset during stall
    ifc.stall = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    chk("sr_valid", ifc.if_valid, 1'b0);
    chk("sr_instr", ifc.if_instr, NOP);
    chk("sr_pc4", ifc.if_pc_plus4, 32'h4);
    chk("sr_addr", ifc.imem_addr, 32'h0);
    ifc.stall = 1'b0;

`ifdef IFETCH_PERF_EN
    mem[4] = 32'h0050_0293;
    tick();
    rst = 1'b0;
    chk("pc_rst", {29'd0, fetch_count}, 32'd0);
    tick(); tick(); tick();
    ifc.stall = 1'b1;
    tick(); tick();
    ifc.stall = 1'b0;
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc = 32'h80;
    tick();
    ifc.redirect_valid = 1'b0;
    tick(); tick();
    chk("pc_five", {29'd0, fetch_count}, 32'd5);
    chk("pc_addr", ifc.imem_addr, 32'h88);
    tick(); tick(); tick(); tick();
    chk("pc_wrap", {29'd0, fetch_count}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule

// File: doc/ifetch_stage.md
Name: ifetch_stage

Overview:
Fetch stage directly upstream of the combinational instruction memory. It owns the PC register and drives the memory word address. It captures the returned instruction into an IF/ID register with valid/stall/flush control. It also detects the halt idiom (beq x0,x0,0 = 32'h00000063) and freezes fetch in a HALTED state.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.
CNT_W, 32, width of the fetch counter (used only when the optional feature is compiled in).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
stall  input  1  downstream hold request; freezes PC and IF/ID register.
redirect_valid  input  1  branch/jump taken; load redirect_pc and flush IF/ID.
redirect_pc  input  32  redirect target; bits [1:0] are ignored and treated as 0.
imem_addr  output  32  byte address to instruction memory; equals pc (combinational from the register).
imem_instr  input  32  instruction word returned combinationally for imem_addr.
if_valid  output  1  IF/ID register holds a real instruction.
if_pc  output  32  PC of the instruction in IF/ID.
if_pc_plus4  output  32  if_pc + 4, modulo 2^32.
if_instr  output  32  captured instruction; 32'h00000013 (NOP) when not valid.
halted  output  1  high while the FSM is in HALTED.

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, if_valid=0, if_pc=RESET_PC, if_pc_plus4=RESET_PC+4, if_instr=NOP, halted=0, state=RUN.
- FSM states: RUN and HALTED. HALTED is left only by reset.
- Priority per rising edge in RUN: redirect_valid > stall > normal fetch.
- Redirect: pc<=redirect_pc & ~3; if_valid<=0; if_instr<=NOP; if_pc and if_pc_plus4 hold their values. Redirect wins over a simultaneous stall and over a simultaneous halt match.
- Stall (without redirect): pc and all IF/ID fields hold.
- Normal fetch:
  - if_instr<=imem_instr, if_pc<=pc, if_pc_plus4<=pc+4, if_valid<=1.
  - If imem_instr==32'h00000063: state<=HALTED and pc holds. Otherwise pc<=pc+4, wrapping 32'hFFFF_FFFC -> 0.
- Latency: an instruction at pc appears on if_* one edge after it is addressed. The first valid instruction appears on the first edge after reset release.
- HALTED:
  - pc frozen; halted=1.
  - IF/ID keeps the halt instruction with if_valid=1 while stall=1.
  - Once stall=0, the next edge sets if_valid<=0 and if_instr<=NOP, so the halt is issued exactly once.
  - redirect_valid and stall are otherwise ignored in HALTED.
- Reset asserted mid-operation, including during stall or HALTED, immediately returns every output to its reset value.

Optional Feature:
Macro IFETCH_PERF_EN.
- Defined: adds output fetch_count [CNT_W-1:0], reset to 0. It increments on every edge where IF/ID loads with if_valid<=1, including the halt instruction, and wraps at 2^CNT_W.
- Not defined: the port and counter do not exist and all other behaviour is identical.

Decomposition:
- Shared package rv_fetch_pkg holds:
  - NOP_INSTR = 32'h00000013
  - HALT_INSTR = 32'h00000063
  - the fetch_state_t enum {RUN, HALTED}
  - the constant PC_STEP = 4
- One natural sub-module, pc_reg: the PC register with async reset to RESET_PC and redirect/stall/advance select. ifetch_stage instantiates it and keeps the IF/ID register and FSM itself.

Test Plan:
- Reset release with memory holding addi words at 0x0, 0x4, 0x8 -> imem_addr steps 0x0, 0x4, 0x8, 0xC on consecutive cycles; if_pc lags imem_addr by one cycle; if_valid=1 from the first edge.
- stall=1 for 3 cycles while pc=0x8 -> imem_addr stays 0x8; if_pc=0x4 and if_instr are unchanged; fetch resumes at 0x8 on release.
- redirect_valid=1, redirect_pc=0x0000_0043, with stall=1 in the same cycle -> next cycle pc=0x40, if_valid=0, if_instr=NOP; the following edge captures the word at 0x40.
- Word at 0x10 = 32'h00000063 -> halted=1 and pc frozen at 0x10; if_valid=1 for one cycle, then 0. A later redirect to 0x100 has no effect. Asserting rst returns pc to 0 and halted to 0.
- redirect_valid asserted on the same edge the halt word is fetched -> no halt; pc=redirect target; halted stays 0.
- With IFETCH_PERF_EN defined: 5 fetches, 2 stalls, 1 redirect -> fetch_count=5. With CNT_W=3, 9 fetches -> fetch_count=1.
